axil_cfg_master: RTL

- AXI4-Lite master that drives the accelerator's configuration slave from a simple command stream.
- Used by the SoC-side sequencer and by standalone benches in place of hierarchical register pokes.
- Accepts one read or write command at a time, performs the AXI-Lite transaction, and returns the read data or write response on a response stream.
- Addresses are word offsets into the config register file: byte address = AXIL_BASE_ADDR + (offset << 2).

---
 rtl/axil_cfg_master.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axil_cfg_master.sv
// axil_cfg_master
//   AXI4-Lite master that turns a simple command stream into single AXI-Lite
//   read or write transactions against the accelerator configuration slave,
//   and returns the read data or write response on a response stream.
//   Only one transaction is in flight at any time.
//
//   Byte address = AXIL_BASE_ADDR + (s_cmd_offset << 2), wrapping modulo
//   2^AXIL_ADDR_WIDTH.
//
// Ports
//   clk, rst             single clock; synchronous active-high reset
//   s_cmd_*              command stream in (valid/ready, write, offset, wdata, wstrb)
//   m_rsp_*              response stream out (valid/ready, write echo, rdata, resp)
//   m_axil_*             AXI4-Lite master channels AW, W, B, AR, R
//   timeout_err          sticky watchdog flag (optional build only)
//
// Optional build
//   `define AXIL_CFG_MASTER_TIMEOUT_EN adds a watchdog counter and the
//   timeout_err port. The watchdog only reports; it never abandons a handshake.
module axil_cfg_master #(
  parameter int                         AXIL_WIDTH      = 32,
  parameter int                         AXIL_ADDR_WIDTH = 32,
  parameter int                         STRB_WIDTH      = AXIL_WIDTH / 8,
  parameter logic [AXIL_ADDR_WIDTH-1:0] AXIL_BASE_ADDR  = '0,
  parameter int                         OFFSET_WIDTH    = 8,
  parameter int                         TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_cmd_valid,
  output logic                       s_cmd_ready,
  input  logic                       s_cmd_write,
  input  logic [OFFSET_WIDTH-1:0]    s_cmd_offset,
  input  logic [AXIL_WIDTH-1:0]      s_cmd_wdata,
  input  logic [STRB_WIDTH-1:0]      s_cmd_wstrb,
  output logic                       m_rsp_valid,
  input  logic                       m_rsp_ready,
  output logic                       m_rsp_write,
  output logic [AXIL_WIDTH-1:0]      m_rsp_rdata,
  output logic [1:0]                 m_rsp_resp,
  output logic [AXIL_ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]                 m_axil_awprot,
  output logic                       m_axil_awvalid,
  input  logic                       m_axil_awready,
  output logic [AXIL_WIDTH-1:0]      m_axil_wdata,
  output logic [STRB_WIDTH-1:0]      m_axil_wstrb,
  output logic                       m_axil_wvalid,
  input  logic                       m_axil_wready,
  input  logic [1:0]                 m_axil_bresp,
  input  logic                       m_axil_bvalid,
  output logic                       m_axil_bready,
  output logic [AXIL_ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]                 m_axil_arprot,
  output logic                       m_axil_arvalid,
  input  logic                       m_axil_arready,
  input  logic [AXIL_WIDTH-1:0]      m_axil_rdata,
  input  logic [1:0]                 m_axil_rresp,
  input  logic                       m_axil_rvalid,
  output logic                       m_axil_rready
`ifdef AXIL_CFG_MASTER_TIMEOUT_EN
  , output logic                     timeout_err
`endif
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

  state_t                     state_q, state_d;
  logic                       cmd_ready_q, cmd_ready_d;
  logic                       awvalid_q, awvalid_d;
  logic                       wvalid_q, wvalid_d;
  logic                       bready_q, bready_d;
  logic                       arvalid_q, arvalid_d;
  logic                       rready_q, rready_d;
  logic [AXIL_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXIL_WIDTH-1:0]      wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]      wstrb_q, wstrb_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic                       rsp_write_q, rsp_write_d;
  logic [AXIL_WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                 rsp_resp_q, rsp_resp_d;

  // A channel counts as done once its valid has already dropped or it is
  // handshaking this cycle, so AW and W may finish in either order.
  logic aw_done, w_done;
  assign aw_done = !awvalid_q || m_axil_awready;
  assign w_done  = !wvalid_q  || m_axil_wready;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    case (state_q)
      IDLE: begin
        if (s_cmd_valid && cmd_ready_q) begin
          addr_d      = AXIL_BASE_ADDR + (AXIL_ADDR_WIDTH'(s_cmd_offset) << 2);
          wdata_d     = s_cmd_wdata;
          wstrb_d     = s_cmd_wstrb;
          cmd_ready_d = 1'b0;
          if (s_cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      WR: begin
        if (awvalid_q && m_axil_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axil_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axil_bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axil_bresp;
          state_d     = RSP;
        end
      end
      RD_ADDR: begin
        if (m_axil_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_axil_rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = m_axil_rdata;
          rsp_resp_d  = m_axil_rresp;
          state_d     = RSP;
        end
      end
      RSP: begin
        // Ready for the next command only after the response handshake edge.
        if (m_rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  // One latched address serves both AW and AR; only one is ever valid.
  assign s_cmd_ready    = cmd_ready_q;
  assign m_rsp_valid    = rsp_valid_q;
  assign m_rsp_write    = rsp_write_q;
  assign m_rsp_rdata    = rsp_rdata_q;
  assign m_rsp_resp     = rsp_resp_q;
  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

`ifdef AXIL_CFG_MASTER_TIMEOUT_EN
  localparam int            TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] wd_cnt_q, wd_cnt_d;
  logic          timeout_err_q, timeout_err_d;
  logic          waiting;

  assign waiting = (state_q == WR) || (state_q == WR_RESP) ||
                   (state_q == RD_ADDR) || (state_q == RD_DATA);

  // Counter restarts on every state change and saturates at the limit.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_d != state_q)
      wd_cnt_d = '0;
    else if (waiting && (wd_cnt_q != TMAX))
      wd_cnt_d = wd_cnt_q + TW'(1);
    timeout_err_d = timeout_err_q || (wd_cnt_d == TMAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule
